// File: rtl/remote_cmd_seq.sv
// remote_cmd_seq: host-side command sequencer placed in front of RemoteComm.
// Holds 16-bit tour commands in a FIFO. Commands are issued one at a time:
// pulse snd_cmd, wait for cmd_sent, then wait for the 8-bit response.
// Each response is counted as an ACK or a NAK. Both wait phases time out,
// and err is a sticky error flag.
//
// Optional build macro: REMOTE_CMD_SEQ_RETRY_EN. When defined, a NAK or
// timeout resends the same cmd up to MAX_RETRY times before it is counted.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   push, push_cmd      enqueue a command (dropped and err set when full)
//   full, empty         FIFO status
//   snd_cmd, cmd        one-cycle send strobe and held command to RemoteComm
//   cmd_sent            RemoteComm finished transmitting both bytes
//   resp_rdy, resp      response strobe and byte
//   busy                sequencer is handling a command
//   ack_cnt, nak_cnt    saturating response counters (nak includes timeouts)
//   err                 sticky overflow/timeout flag
//   clr_err             synchronous clear of err and both counters
module remote_cmd_seq #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [19:0] TIMEOUT   = 20'hFFFFF,
  parameter logic [7:0]  ACK_VAL   = 8'hA5,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] push_cmd,
  output logic        full,
  output logic        empty,
  output logic        snd_cmd,
  output logic [15:0] cmd,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        busy,
  output logic [7:0]  ack_cnt,
  output logic [7:0]  nak_cnt,
  output logic        err,
  input  logic        clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_RETRY > 255) begin : g_param_check
    $error("remote_cmd_seq: DEPTH must be a power of 2 >= 2, MAX_RETRY <= 255");
  end

  typedef enum logic [1:0] {IDLE, SEND, WAIT_SENT, WAIT_RESP} state_t;

  state_t        state, state_nxt;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [19:0]   timer;
  logic          do_push, overflow, load;
  logic          tmr_clr, tmr_inc, tmr_exp;
  logic          ack_inc, nak_inc, err_set, fail, timed_out;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  // Push acceptance is judged on the registered count, so a same-cycle pop
  // never makes room for a push into a full FIFO.
  assign do_push  = push && !full;
  assign overflow = push && full;
  assign snd_cmd  = (state == SEND);
  assign busy     = (state != IDLE);
  assign tmr_exp  = (timer == TIMEOUT - 20'd1);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_cmd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (load)    rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef REMOTE_CMD_SEQ_RETRY_EN
  logic [7:0] attempt;
  logic       retry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        attempt <= '0;
    else if (load)  attempt <= '0;
    else if (retry) attempt <= attempt + 1'b1;
  end
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    ack_inc   = 1'b0;
    nak_inc   = 1'b0;
    fail      = 1'b0;
    timed_out = 1'b0;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
    retry     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!empty) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        tmr_clr   = 1'b1;
        state_nxt = WAIT_SENT;
      end
      WAIT_SENT: begin
        // cmd_sent wins over a same-cycle resp_rdy, which is ignored here.
        if (cmd_sent) begin
          tmr_clr   = 1'b1;
          state_nxt = WAIT_RESP;
        end else if (tmr_exp) begin
          fail      = 1'b1;
          timed_out = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (resp_rdy) begin
          if (resp == ACK_VAL) begin
            ack_inc   = 1'b1;
            state_nxt = IDLE;
          end else begin
            fail = 1'b1;
          end
        end else if (tmr_exp) begin
          fail      = 1'b1;
          timed_out = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (fail) begin
`ifdef REMOTE_CMD_SEQ_RETRY_EN
      if (attempt < MAX_RETRY[7:0]) begin
        retry     = 1'b1;
        state_nxt = SEND;
      end else begin
        nak_inc   = 1'b1;
        state_nxt = IDLE;
      end
`else
      nak_inc   = 1'b1;
      state_nxt = IDLE;
`endif
    end
    err_set = overflow || (nak_inc && timed_out);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cmd     <= '0;
      timer   <= '0;
      ack_cnt <= '0;
      nak_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) cmd <= mem[rd_ptr];
      if (tmr_clr)      timer <= '0;
      else if (tmr_inc) timer <= timer + 1'b1;
      if (clr_err) begin
        ack_cnt <= '0;
        nak_cnt <= '0;
        err     <= 1'b0;
      end else begin
        if (ack_inc && ack_cnt != '1) ack_cnt <= ack_cnt + 1'b1;
        if (nak_inc && nak_cnt != '1) nak_cnt <= nak_cnt + 1'b1;
        if (err_set) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_remote_cmd_seq.sv
module tb_remote_cmd_seq;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO    = 64;
  localparam logic [7:0]  ACK   = 8'hA5;
  localparam int unsigned MAXR  = 2;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
  localparam int NWAIT = (MAXR + 1) * (TO + 6);
`else
  localparam int NWAIT = TO + 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        push = 1'b0, cmd_sent = 1'b0, resp_rdy = 1'b0, clr_err = 1'b0;
  logic [15:0] push_cmd = '0;
  logic [7:0]  resp = '0;
  logic        full, empty, snd_cmd, busy, err;
  logic [15:0] cmd;
  logic [7:0]  ack_cnt, nak_cnt;

  int vectors = 0;
  int miscompares = 0;

  remote_cmd_seq #(.DEPTH(DEPTH), .TIMEOUT(20'd64), .ACK_VAL(ACK), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .push(push), .push_cmd(push_cmd), .full(full), .empty(empty),
    .snd_cmd(snd_cmd), .cmd(cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
    .busy(busy), .ack_cnt(ack_cnt), .nak_cnt(nak_cnt), .err(err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending commands plus the job in flight.
  // job: 0 none, 1 strobe cycle, 2 awaiting transmit, 3 awaiting response.
  logic [15:0] mq[$];
  int          m_job = 0, m_age = 0, m_tries = 0, m_ack = 0, m_nak = 0;
  logic [15:0] m_cmd = '0;
  bit          m_err = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_job = 0; m_age = 0; m_tries = 0; m_ack = 0; m_nak = 0; m_cmd = '0; m_err = 0;
    end else begin
      int sz;
      bit got_ack, got_nak, got_err, failed, tmo;
      sz = mq.size();
      got_ack = 0; got_nak = 0; got_err = 0; failed = 0; tmo = 0;
      case (m_job)
        0: if (sz > 0) begin m_cmd = mq.pop_front(); m_job = 1; m_tries = 0; end
        1: begin m_job = 2; m_age = 0; end
        2: if (cmd_sent) begin m_job = 3; m_age = 0; end
           else if (m_age == TO - 1) begin failed = 1; tmo = 1; end
           else m_age++;
        default:
           if (resp_rdy) begin
             if (resp == ACK) begin got_ack = 1; m_job = 0; end
             else failed = 1;
           end else if (m_age == TO - 1) begin failed = 1; tmo = 1; end
           else m_age++;
      endcase
      if (failed) begin
`ifdef REMOTE_CMD_SEQ_RETRY_EN
        if (m_tries < MAXR) begin m_tries++; m_job = 1; end
        else begin got_nak = 1; got_err = tmo; m_job = 0; end
`else
        got_nak = 1; got_err = tmo; m_job = 0;
`endif
      end
      if (push) begin
        if (sz == DEPTH) got_err = 1;
        else mq.push_back(push_cmd);
      end
      if (clr_err) begin
        m_ack = 0; m_nak = 0; m_err = 0;
      end else begin
        if (got_ack && m_ack < 255) m_ack++;
        if (got_nak && m_nak < 255) m_nak++;
        if (got_err) m_err = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("snd_cmd", 32'(snd_cmd), 32'(m_job == 1));
    chk("cmd",     32'(cmd),     32'(m_cmd));
    chk("busy",    32'(busy),    32'(m_job != 0));
    chk("empty",   32'(empty),   32'(mq.size() == 0));
    chk("full",    32'(full),    32'(mq.size() == DEPTH));
    chk("ack_cnt", 32'(ack_cnt), 32'(m_ack));
    chk("nak_cnt", 32'(nak_cnt), 32'(m_nak));
    chk("err",     32'(err),     32'(m_err));
  end

  logic [15:0] snd_log[$];
  int          snd_used = 0;
  always @(negedge clk) if (snd_cmd) snd_log.push_back(cmd);

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic do_push(input logic [15:0] c);
    push = 1'b1; push_cmd = c; tick(); push = 1'b0;
  endtask

  task automatic do_clr();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
  endtask

  task automatic sync_log();
    snd_used = snd_log.size();
  endtask

  task automatic take_snd(input logic [15:0] exp);
    int n = 0;
    while (snd_log.size() <= snd_used && n < 300) begin tick(); n++; end
    chk("snd_seen", 32'(snd_log.size() > snd_used), 32'd1);
    if (snd_log.size() > snd_used) begin
      chk("snd_order", 32'(snd_log[snd_used]), 32'(exp));
      snd_used++;
    end
    if (snd_cmd) tick();
  endtask

  task automatic serve(input logic [15:0] exp, input int dly, input logic [7:0] r);
    take_snd(exp);
    repeat (dly - 1) tick();
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    tick();
    resp_rdy = 1'b1; resp = r; tick(); resp_rdy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_snd",   32'(snd_cmd), 32'd0);
    chk("rst_cmd",   32'(cmd),     32'h0);
    chk("rst_empty", 32'(empty),   32'd1);
    chk("rst_full",  32'(full),    32'd0);
    chk("rst_busy",  32'(busy),    32'd0);
    chk("rst_cnt",   32'({ack_cnt, nak_cnt, 7'd0, err}), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single command, ACK after a 10-cycle transmit
    do_push(16'hFFFF);
    serve(16'hFFFF, 10, ACK);
    repeat (2) tick();
    chk("t1_pulses", 32'(snd_log.size()), 32'd1);
    chk("t1_cmd",    32'(cmd),     32'hFFFF);
    chk("t1_ack",    32'(ack_cnt), 32'd1);
    chk("t1_err",    32'(err),     32'd0);
    chk("t1_busy",   32'(busy),    32'd0);

    // 2: three back-to-back pushes answered in order
    do_clr();
    do_push(16'h1234); do_push(16'h8BA2); do_push(16'h0000);
    serve(16'h1234, 1, ACK);
    serve(16'h8BA2, 2, ACK);
    serve(16'h0000, 1, ACK);
    repeat (2) tick();
    chk("t2_ack",   32'(ack_cnt), 32'd3);
    chk("t2_empty", 32'(empty),   32'd1);

    // 3: overflow while stalled awaiting cmd_sent
    sync_log();
    do_push(16'h0100);
    take_snd(16'h0100);
    for (int i = 1; i <= 9; i++) do_push(16'h0100 + 16'(i));
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_err",  32'(err),  32'd1);
    do_clr();
    chk("t3_clr", 32'({ack_cnt, nak_cnt, 7'd0, err}), 32'd0);
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0; tick();
    resp_rdy = 1'b1; resp = ACK; tick(); resp_rdy = 1'b0;
    for (int i = 1; i <= 8; i++) serve(16'h0100 + 16'(i), 1, ACK);
    repeat (3) tick();
    chk("t3_ack",   32'(ack_cnt), 32'd9);
    chk("t3_empty", 32'(empty),   32'd1);
    chk("t3_drop",  32'(snd_log.size() - snd_used), 32'd0);

    // 4: NAK response
    do_clr();
    do_push(16'hBEEF);
    serve(16'hBEEF, 1, 8'h5A);
`ifdef REMOTE_CMD_SEQ_RETRY_EN
    repeat (MAXR) serve(16'hBEEF, 1, 8'h5A);
`endif
    repeat (2) tick();
    chk("t4_nak", 32'(nak_cnt), 32'd1);
    chk("t4_ack", 32'(ack_cnt), 32'd0);
    chk("t4_err", 32'(err),     32'd0);

    // cmd_sent and resp_rdy together: only cmd_sent counts; idle strobes ignored
    do_clr();
    do_push(16'h7777);
    take_snd(16'h7777);
    cmd_sent = 1'b1; resp_rdy = 1'b1; resp = ACK; tick();
    cmd_sent = 1'b0; resp_rdy = 1'b0; tick();
    resp_rdy = 1'b1; resp = 8'h5A; tick(); resp_rdy = 1'b0;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
    repeat (MAXR) serve(16'h7777, 1, 8'h5A);
`endif
    repeat (2) tick();
    resp_rdy = 1'b1; resp = ACK; cmd_sent = 1'b1; tick();
    resp_rdy = 1'b0; cmd_sent = 1'b0; tick();
    chk("both_ack", 32'(ack_cnt), 32'd0);
    chk("both_nak", 32'(nak_cnt), 32'd1);

    // 5: transmit timeout
    do_clr();
    sync_log();
    do_push(16'h00C3);
    take_snd(16'h00C3);
    repeat (NWAIT) tick();
    chk("t5_err",  32'(err),     32'd1);
    chk("t5_nak",  32'(nak_cnt), 32'd1);
    chk("t5_busy", 32'(busy),    32'd0);

    // response timeout
    do_clr();
    sync_log();
    do_push(16'h00C4);
    take_snd(16'h00C4);
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    repeat (NWAIT) tick();
    chk("rt_err",  32'(err),     32'd1);
    chk("rt_nak",  32'(nak_cnt), 32'd1);
    chk("rt_busy", 32'(busy),    32'd0);

    // ACK counter saturates
    do_clr();
    sync_log();
    for (int i = 0; i < 257; i++) begin
      do_push(16'(i));
      serve(16'(i), 1, ACK);
    end
    repeat (2) tick();
    chk("sat_ack", 32'(ack_cnt), 32'hFF);

    // 6: reset while awaiting a response with three queued
    do_clr();
    sync_log();
    do_push(16'h0A01); do_push(16'h0A02); do_push(16'h0A03); do_push(16'h0A04);
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    chk("t6_inresp", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_snd",   32'(snd_cmd), 32'd0);
    chk("t6_busy",  32'(busy),    32'd0);
    chk("t6_empty", 32'(empty),   32'd1);
    tick(); tick();
    rst = 1'b0;
    tick();
    resp_rdy = 1'b1; resp = ACK; tick(); resp_rdy = 1'b0;
    repeat (2) tick();
    chk("t6_ack",  32'(ack_cnt), 32'd0);
    chk("t6_idle", 32'(busy),    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/remote_cmd_seq.md
Name: remote_cmd_seq

Overview:
- Host-side command sequencer that sits directly upstream of RemoteComm and drives its snd_cmd/cmd inputs.
- Buffers 16-bit tour commands in a FIFO and issues them one at a time.
- Waits for cmd_sent, then for the 8-bit response (resp_rdy/resp) returned from the UART_wrapper side.
- Classifies each response as ACK or NAK, with timeout protection and sticky error reporting.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2.
TIMEOUT, 20'hFFFFF, cycles allowed per wait phase (WAIT_SENT and WAIT_RESP independently).
ACK_VAL, 8'hA5, response value counted as positive acknowledge.
MAX_RETRY, 2, resend attempts per command; used only when RETRY_EN is defined.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
push  in  1  write push_cmd into FIFO.
push_cmd  in  16  command to enqueue.
full  out  1  FIFO count == DEPTH.
empty  out  1  FIFO count == 0.
snd_cmd  out  1  one-cycle pulse to RemoteComm.
cmd  out  16  command presented to RemoteComm; stable from SEND until next load.
cmd_sent  in  1  from RemoteComm: both bytes transmitted.
resp_rdy  in  1  from RemoteComm: resp valid this cycle.
resp  in  8  response byte.
busy  out  1  state != IDLE.
ack_cnt  out  8  ACK count, saturates at 8'hFF.
nak_cnt  out  8  NAK-plus-timeout count, saturates at 8'hFF.
err  out  1  sticky: overflow or timeout occurred.
clr_err  in  1  synchronous clear of err, ack_cnt and nak_cnt.

Behaviour:
- Reset values: snd_cmd=0, cmd=16'h0000, FIFO pointers and count=0 (empty=1, full=0), busy=0, ack_cnt=0, nak_cnt=0, err=0, state=IDLE, timer=0.
- FIFO push: push accepted only when !full, judged on the registered count before any same-cycle pop.
- FIFO overflow: push while full drops the data and sets err.
- Simultaneous push and pop with count in 1..DEPTH-1: count is unchanged and both pointers advance (wrap modulo DEPTH).
- State machine: IDLE, SEND, WAIT_SENT, WAIT_RESP.
- IDLE: if !empty, cmd <= FIFO head, pop, go to SEND. Otherwise stay.
- SEND: snd_cmd=1 for exactly this cycle (Moore output). Timer cleared; go to WAIT_SENT.
- WAIT_SENT: on cmd_sent, clear timer and go to WAIT_RESP. If timer reaches TIMEOUT-1 first, set err, nak_cnt++ and go to IDLE.
- WAIT_RESP: on resp_rdy, if resp==ACK_VAL then ack_cnt++, else nak_cnt++; go to IDLE. If timer reaches TIMEOUT-1 first, set err, nak_cnt++ and go to IDLE.
- resp_rdy or cmd_sent outside its own wait state is ignored.
- If cmd_sent and resp_rdy assert in the same WAIT_SENT cycle, only cmd_sent is taken.
- Latency: push into an empty FIFO while IDLE gives snd_cmd high 2 cycles after the push edge (1 cycle to enqueue, 1 cycle to load).
- Back-to-back commands: minimum gap from a response to the next snd_cmd is 2 cycles (IDLE, then SEND).
- clr_err clears err, ack_cnt and nak_cnt the next edge. It has priority over a same-cycle increment or error set.
- Reset mid-transaction: all state aborts immediately, FIFO contents are discarded, and snd_cmd drops asynchronously.
- Counter width rule: both counters saturate at 8'hFF and never wrap.

Optional Feature:
- Macro: REMOTE_CMD_SEQ_RETRY_EN.
- Defined: a NAK or timeout with attempt count < MAX_RETRY returns to SEND with the same cmd (no FIFO pop) and increments the attempt count. nak_cnt and err update only when the final attempt fails. The attempt count resets on each new load from the FIFO.
- Undefined: no retry; every NAK or timeout moves on to the next FIFO entry. MAX_RETRY is unused.

Test Plan:
1. Reset, push 16'hFFFF, cmd_sent 10 cycles after snd_cmd, then resp_rdy with resp=8'hA5 -> one snd_cmd pulse, cmd=16'hFFFF, ack_cnt=1, err=0, busy returns to 0.
2. Push 16'h1234, 16'h8BA2, 16'h0000 back-to-back, each answered with 8'hA5 -> three snd_cmd pulses in push order, ack_cnt=3, empty=1 at end.
3. Push DEPTH+1=9 commands while the sequencer is stalled in WAIT_SENT -> full=1 after 8 are stored (one was already popped), the ninth is dropped, err=1. clr_err -> err=0 and counters=0.
4. Push 16'hBEEF, respond 8'h5A -> nak_cnt=1, ack_cnt=0. With REMOTE_CMD_SEQ_RETRY_EN, a second snd_cmd with cmd=16'hBEEF follows.
5. Push 16'h00C3, never assert cmd_sent -> after TIMEOUT cycles err=1, nak_cnt=1, state returns to IDLE. Run this case with TIMEOUT overridden to 64.
6. Assert rst during WAIT_RESP with 3 entries queued -> snd_cmd=0, busy=0, empty=1 immediately. A later resp_rdy does not change ack_cnt.
